acl2_sampler: RTL and testbench



---
 rtl/acl2_sampler.sv | 265 ++++++++++++++++++++++++++
 tb/tb_acl2_sampler.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acl2_sampler.sv
// acl2_sampler: autonomous ADXL362 X/Y/Z burst reader driving the SPI core FIFOs.
// One burst per trigger; chip select, FIFO strobes and sample registers are all flopped.
module acl2_sampler #(
    parameter logic [15:0] SAMPLE_DIV = 16'd50000,
    parameter logic [7:0]  CMD_READ   = 8'h0B,
    parameter logic [7:0]  START_ADDR = 8'h0E,
    parameter int unsigned CS_GAP     = 4,
    parameter logic [15:0] TIMEOUT    = 16'd4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic        clear_ovr,
    input  logic [7:0]  spsr,
    input  logic [7:0]  rfdout,
    output logic        wfwe,
    output logic [7:0]  wfdin,
    output logic        rfre,
    output logic        ncs_o,
    output logic        busy,
    output logic        sample_valid,
    output logic [15:0] x_data,
    output logic [15:0] y_data,
    output logic [15:0] z_data,
    output logic        error,
    output logic        overrun
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FLUSH,
        S_CS_SETUP,
        S_SEND,
        S_WAIT_RX,
        S_READ,
        S_CS_HOLD,
        S_DONE,
        S_ABORT
    } state_t;

    localparam logic [15:0] TMR_RELOAD = SAMPLE_DIV - 16'd1;
    localparam logic [15:0] SETUP_LAST = 16'(CS_GAP);
    localparam logic [15:0] HOLD_LAST  = (CS_GAP > 0) ? 16'(CS_GAP - 1) : 16'd0;
    localparam logic [15:0] TMO_LAST   = TIMEOUT - 16'd1;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        pending_q, pending_d;
    logic        overrun_q, overrun_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [47:0] sh_q, sh_d;
    logic        wfwe_q, wfwe_d;
    logic [7:0]  wfdin_q, wfdin_d;
    logic        rfre_q, rfre_d;
    logic        ncs_q, ncs_d;
    logic        busy_q, busy_d;
    logic        sv_q, sv_d;
    logic        err_q, err_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [15:0] z_q, z_d;

    logic rf_empty;
    logic tmr_fire;
    logic trig;
    logic unused_spsr;

    assign rf_empty    = spsr[0];
    assign unused_spsr = ^{spsr[7:1]};

    function automatic logic [7:0] tx_byte(input logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0:    b = CMD_READ;
            3'd1:    b = START_ADDR;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Trigger, pending and sticky overrun bookkeeping
    always_comb begin
        timer_d   = timer_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        tmr_fire  = enable && (timer_q == 16'd0);
        trig      = start || tmr_fire;

        if (!enable || timer_q == 16'd0) begin
            timer_d = TMR_RELOAD;
        end else begin
            timer_d = timer_q - 16'd1;
        end

        if (state_q == S_IDLE && pending_q) begin
            pending_d = 1'b0;
        end
        if (trig && !pending_q) begin
            pending_d = 1'b1;
        end

        if (clear_ovr) begin
            overrun_d = 1'b0;
        end
        if (trig && pending_q) begin
            overrun_d = 1'b1;
        end
    end

    // Sequencer; strobes are set on entry so they are high in the named state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        wfwe_d  = 1'b0;
        wfdin_d = wfdin_q;
        rfre_d  = 1'b0;
        ncs_d   = ncs_q;
        sv_d    = 1'b0;
        err_d   = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;

        unique case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // pop on alternate cycles so rfempty reflects each pop
                if (!rfre_q) begin
                    if (!rf_empty) begin
                        rfre_d = 1'b1;
                    end else begin
                        ncs_d   = 1'b0;
                        cnt_d   = 16'd0;
                        idx_d   = 3'd0;
                        state_d = S_CS_SETUP;
                    end
                end
            end
            S_CS_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    wfwe_d  = 1'b1;
                    wfdin_d = tx_byte(idx_q);
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SEND: begin
                cnt_d   = 16'd0;
                state_d = S_WAIT_RX;
            end
            S_WAIT_RX: begin
                if (!rf_empty) begin
                    rfre_d  = 1'b1;
                    state_d = S_READ;
                end else if (cnt_q == TMO_LAST) begin
                    ncs_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_ABORT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_READ: begin
                idx_d = idx_q + 3'd1;
                if (idx_q >= 3'd2) begin
                    sh_d = {rfdout, sh_q[47:8]};
                end
                if (idx_q == 3'd7) begin
                    cnt_d   = 16'd0;
                    state_d = S_CS_HOLD;
                end else begin
                    wfwe_d  = 1'b1;
                    wfdin_d = tx_byte(idx_q + 3'd1);
                    state_d = S_SEND;
                end
            end
            S_CS_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    ncs_d   = 1'b1;
                    sv_d    = 1'b1;
                    x_d     = sh_q[15:0];
                    y_d     = sh_q[31:16];
                    z_d     = sh_q[47:32];
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                ncs_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= TMR_RELOAD;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            cnt_q     <= 16'd0;
            idx_q     <= 3'd0;
            sh_q      <= 48'd0;
            wfwe_q    <= 1'b0;
            wfdin_q   <= 8'd0;
            rfre_q    <= 1'b0;
            ncs_q     <= 1'b1;
            busy_q    <= 1'b0;
            sv_q      <= 1'b0;
            err_q     <= 1'b0;
            x_q       <= 16'd0;
            y_q       <= 16'd0;
            z_q       <= 16'd0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sh_q      <= sh_d;
            wfwe_q    <= wfwe_d;
            wfdin_q   <= wfdin_d;
            rfre_q    <= rfre_d;
            ncs_q     <= ncs_d;
            busy_q    <= busy_d;
            sv_q      <= sv_d;
            err_q     <= err_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
        end
    end

    assign wfwe         = wfwe_q;
    assign wfdin        = wfdin_q;
    assign rfre         = rfre_q;
    assign ncs_o        = ncs_q;
    assign busy         = busy_q;
    assign sample_valid = sv_q;
    assign error        = err_q;
    assign overrun      = overrun_q;
    assign x_data       = x_q;
    assign y_data       = y_q;
    assign z_data       = z_q;

endmodule

// File: tb/tb_acl2_sampler.sv
// tb_acl2_sampler: randomized scoreboard bench for acl2_sampler with a
// behavioural SPI core model (byte-in-flight delay plus read FIFO queue).
module tb_acl2_sampler;

    localparam int DIV = 200;
    localparam int GAP = 4;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic        clear_ovr = 1'b0;
    logic [7:0]  spsr;
    logic [7:0]  rfdout;
    logic        wfwe;
    logic [7:0]  wfdin;
    logic        rfre;
    logic        ncs_o;
    logic        busy;
    logic        sample_valid;
    logic [15:0] x_data;
    logic [15:0] y_data;
    logic [15:0] z_data;
    logic        error;
    logic        overrun;

    acl2_sampler #(
        .SAMPLE_DIV(16'(DIV)),
        .CS_GAP(GAP),
        .TIMEOUT(16'(TMO))
    ) dut (
        .clk(clk),
        .reset(rst),
        .enable(enable),
        .start(start),
        .clear_ovr(clear_ovr),
        .spsr(spsr),
        .rfdout(rfdout),
        .wfwe(wfwe),
        .wfdin(wfdin),
        .rfre(rfre),
        .ncs_o(ncs_o),
        .busy(busy),
        .sample_valid(sample_valid),
        .x_data(x_data),
        .y_data(y_data),
        .z_data(z_data),
        .error(error),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] resp_q[$];
    logic [7:0] rxq[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_lat = 8;
    int inj_req = 0;
    int inj_ack = 0;
    bit periodic = 0;
    int flush_cnt = 0;
    int bi = 0;

    function automatic void chk(string name, longint act, longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // SPI core model: each pushed byte answers after n_lat cycles, if a
    // response byte is queued; otherwise the slave stays silent.
    int         cd = 0;
    bit         inflight = 0;
    logic [7:0] cur = 8'h00;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rxq.delete();
            inflight = 0;
            cd = 0;
        end else begin
            if (rfre) begin
                chk("rf_underflow", longint'(rxq.size() != 0), 1);
                if (rxq.size() != 0) void'(rxq.pop_front());
            end
            if (inflight) begin
                cd--;
                if (cd == 0) begin
                    inflight = 0;
                    rxq.push_back(cur);
                end
            end
            if (wfwe) begin
                chk("one_in_flight", longint'(inflight), 0);
                if (resp_q.size() != 0) begin
                    cur = resp_q.pop_front();
                    inflight = 1;
                    cd = n_lat;
                end
            end
            while (inj_ack < inj_req) begin
                rxq.push_back(8'hA5 ^ 8'(inj_ack));
                inj_ack++;
            end
        end
        spsr   <= {5'b0, 1'b1, 1'b0, rxq.size() == 0};
        rfdout <= (rxq.size() != 0) ? rxq[0] : 8'h00;
    end

    // Monitor: protocol checks plus scoreboard on sample_valid / error
    int          fall_cyc = 0;
    int          last_wfwe = 0;
    int          last_rfre = 0;
    int          last_sv = 0;
    bit          have_sv = 0;
    logic        ncs_prev = 1'b1;
    logic [15:0] gx = 0;
    logic [15:0] gy = 0;
    logic [15:0] gz = 0;
    always @(negedge clk) begin : mon
        exp_t       e;
        logic [7:0] eb;
        if (!periodic) have_sv = 0;
        if (rst) begin
            ncs_prev = 1'b1;
            bi = 0;
            gx = 0;
            gy = 0;
            gz = 0;
        end else begin
            if (ncs_prev && !ncs_o) begin
                fall_cyc = cyc;
                bi = 0;
            end
            if (!ncs_prev && ncs_o && !error)
                chk("hold_gap", longint'(cyc - last_rfre), longint'(GAP + 1));
            if (wfwe) begin
                eb = (bi == 0) ? 8'h0B : (bi == 1) ? 8'h0E : 8'h00;
                chk("wfdin", longint'(wfdin), longint'(eb));
                chk("ncs_low_on_write", longint'(ncs_o), 0);
                if (bi == 0)
                    chk("setup_gap", longint'(cyc - fall_cyc), longint'(GAP + 1));
                bi++;
                last_wfwe = cyc;
            end
            if (rfre) begin
                if (ncs_o) flush_cnt++;
                last_rfre = cyc;
            end
            if (sample_valid || error) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", longint'({sample_valid, error}), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", longint'(error), longint'(e.err));
                    if (!e.err) begin
                        chk("x_data", longint'(x_data), longint'(e.x));
                        chk("y_data", longint'(y_data), longint'(e.y));
                        chk("z_data", longint'(z_data), longint'(e.z));
                        chk("bytes_written", longint'(bi), 8);
                        chk("ncs_high_done", longint'(ncs_o), 1);
                        gx = e.x;
                        gy = e.y;
                        gz = e.z;
                        if (periodic) begin
                            if (have_sv)
                                chk("period", longint'(cyc - last_sv), longint'(DIV));
                            last_sv = cyc;
                            have_sv = 1;
                        end
                    end else begin
                        chk("abort_x_kept", longint'(x_data), longint'(gx));
                        chk("abort_y_kept", longint'(y_data), longint'(gy));
                        chk("abort_z_kept", longint'(z_data), longint'(gz));
                        chk("ncs_high_abort", longint'(ncs_o), 1);
                        chk("tmo_latency",
                            longint'((cyc - last_wfwe >= TMO) && (cyc - last_wfwe <= TMO + 1)), 1);
                    end
                end
            end
            ncs_prev = ncs_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        exp_t e;
        resp_q.push_back(8'h00);
        resp_q.push_back(8'h00);
        resp_q.push_back(x[7:0]);
        resp_q.push_back(x[15:8]);
        resp_q.push_back(y[7:0]);
        resp_q.push_back(y[15:8]);
        resp_q.push_back(z[7:0]);
        resp_q.push_back(z[15:8]);
        e.err = 0;
        e.x = x;
        e.y = y;
        e.z = z;
        exp_q.push_back(e);
    endtask

    task automatic push_random();
        push_sample(16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_ovr = 1'b1;
        tick();
        clear_ovr = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        tick();
        while ((exp_q.size() != 0 || busy) && n < lim) begin
            tick();
            n++;
        end
        chk("done_in_time", longint'(n < lim), 1);
    endtask

    initial begin : stim
        exp_t e;
        int   f0;
        int   n;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ncs", longint'(ncs_o), 1);
        chk("rst_wfwe", longint'(wfwe), 0);
        chk("rst_rfre", longint'(rfre), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_sv", longint'(sample_valid), 0);
        chk("rst_err", longint'(error), 0);
        chk("rst_ovr", longint'(overrun), 0);
        chk("rst_wfdin", longint'(wfdin), 0);
        chk("rst_xyz", longint'({x_data, y_data, z_data}), 0);
        rst = 1'b0;
        tick();

        n_lat = 8;
        push_sample(16'h1234, 16'h5678, 16'h9ABC);
        pulse_start();
        wait_done(400);

        for (int i = 0; i < 6; i++) begin
            n_lat = int'($urandom_range(2, 12));
            push_random();
            pulse_start();
            wait_done(600);
        end

        n_lat = 8;
        for (int i = 0; i < 4; i++) push_random();
        periodic = 1;
        enable = 1'b1;
        wait_done(1500);
        enable = 1'b0;
        periodic = 0;
        chk("periodic_no_ovr", longint'(overrun), 0);
        repeat (5) tick();

        push_random();
        pulse_start();
        repeat (10) tick();
        push_random();
        pulse_start();
        chk("ovr_pending_only", longint'(overrun), 0);
        pulse_start();
        chk("ovr_set", longint'(overrun), 1);
        wait_done(800);
        chk("ovr_sticky", longint'(overrun), 1);
        pulse_clear();
        chk("ovr_cleared", longint'(overrun), 0);

        push_random();
        pulse_start();
        repeat (10) tick();
        push_random();
        pulse_start();
        start = 1'b1;
        clear_ovr = 1'b1;
        tick();
        start = 1'b0;
        clear_ovr = 1'b0;
        chk("ovr_set_wins", longint'(overrun), 1);
        wait_done(800);
        pulse_clear();
        chk("ovr_cleared2", longint'(overrun), 0);

        resp_q.push_back(8'h00);
        resp_q.push_back(8'h00);
        resp_q.push_back(8'($urandom));
        resp_q.push_back(8'($urandom));
        e.err = 1;
        e.x = 0;
        e.y = 0;
        e.z = 0;
        exp_q.push_back(e);
        pulse_start();
        wait_done(800);
        push_random();
        pulse_start();
        wait_done(600);

        f0 = flush_cnt;
        inj_req += 2;
        repeat (3) tick();
        push_random();
        pulse_start();
        wait_done(600);
        chk("flush_pulses", longint'(flush_cnt - f0), 2);

        push_random();
        pulse_start();
        n = 0;
        while (bi < 5 && n < 500) begin
            tick();
            n++;
        end
        chk("reach_byte4", longint'(bi >= 5), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ncs", longint'(ncs_o), 1);
        chk("mid_rst_busy", longint'(busy), 0);
        chk("mid_rst_strobes", longint'({wfwe, rfre, sample_valid, error}), 0);
        chk("mid_rst_xyz", longint'({x_data, y_data, z_data}), 0);
        exp_q.delete();
        resp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("post_rst_idle", longint'(busy), 0);
        push_random();
        pulse_start();
        wait_done(600);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
